// File: rtl/mem_stage_ctrl_pkg.sv
// lc3b_types: shared LC-3b word, opcode and instruction-packet types plus MEM-stage helpers.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [3:0] {
    op_br  = 4'b0000, op_add = 4'b0001, op_ldb = 4'b0010, op_stb = 4'b0011,
    op_jsr = 4'b0100, op_and = 4'b0101, op_ldr = 4'b0110, op_str = 4'b0111,
    op_rti = 4'b1000, op_not = 4'b1001, op_ldi = 4'b1010, op_sti = 4'b1011,
    op_jmp = 4'b1100, op_shf = 4'b1101, op_lea = 4'b1110, op_trap = 4'b1111
  } lc3b_opcode;
  typedef struct packed {
    lc3b_opcode opcode;
    logic [2:0] dr;
    lc3b_word   pc;
  } lc3b_ipacket;
  typedef enum logic [1:0] {IDLE, ACC1, PTR, ACC2} mem_state_t;
  function automatic logic is_mem_op(lc3b_opcode op);
    return op inside {op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti};
  endfunction
  function automatic logic is_load_op(lc3b_opcode op);
    return op inside {op_ldr, op_ldb, op_ldi};
  endfunction
endpackage

// File: rtl/mem_stage_ctrl_byte_align.sv
// mem_byte_align: byte-lane write mask/data replication and LDB byte extract/extend.
module mem_byte_align
  import lc3b_types::*;
#(
  parameter bit LDB_SEXT = 1'b1
) (
  input  logic       byte_op,
  input  logic       addr0,
  input  lc3b_word   sr,
  input  lc3b_word   rdata,
  output logic [1:0] wmask,
  output lc3b_word   wdata,
  output lc3b_word   ldb_data
);
  logic [7:0] b;
  always_comb begin
    b        = addr0 ? rdata[15:8] : rdata[7:0];
    wmask    = !byte_op ? 2'b11 : addr0 ? 2'b10 : 2'b01;
    wdata    = byte_op ? {sr[7:0], sr[7:0]} : sr;
    ldb_data = {{8{LDB_SEXT && b[7]}}, b};
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage sequencer for single and indirect data-memory accesses.
// Stall and request outputs depend only on registered state so the upstream stall loop stays open.
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter bit LDB_SEXT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  lc3b_ipacket in_ipacket,
  input  lc3b_word    meat_alu_out,
  input  lc3b_word    meat_addrgen_out,
  input  lc3b_word    sr_store_in,
  input  logic        hold,
  input  lc3b_word    dmem_rdata,
  input  logic        dmem_resp,
  output lc3b_word    dmem_addr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_wmask,
  output lc3b_word    dmem_wdata,
  output logic        load_addr,
  output logic        mem_stall,
  output lc3b_ipacket out_ipacket,
  output lc3b_word    alu_pass_out,
  output lc3b_word    mem_rdata_out
);
  mem_state_t  state_q, state_d;
  lc3b_ipacket pkt_q, pkt_d, out_pkt_q, out_pkt_d;
  lc3b_word    addr_q, addr_d, sr_q, sr_d, alu_q, alu_d;
  lc3b_word    alu_out_q, alu_out_d, rdata_out_q, rdata_out_d, ldb_data;
  logic        hold_q, hold_d, acc, ptr_rd, ld, done;
  mem_byte_align #(.LDB_SEXT(LDB_SEXT)) u_align (
    .byte_op (!ptr_rd && (pkt_q.opcode == op_ldb || pkt_q.opcode == op_stb)),
    .addr0   (addr_q[0]),
    .sr      (sr_q),
    .rdata   (dmem_rdata),
    .wmask   (dmem_wmask),
    .wdata   (dmem_wdata),
    .ldb_data(ldb_data)
  );
  always_comb begin
    acc         = state_q == ACC1 || state_q == ACC2;
    ptr_rd      = state_q == ACC1 && hold_q;
    ld          = is_load_op(pkt_q.opcode);
    done        = acc && dmem_resp && !ptr_rd;
    state_d     = state_q;
    pkt_d       = pkt_q;
    addr_d      = addr_q;
    sr_d        = sr_q;
    alu_d       = alu_q;
    hold_d      = hold_q;
    out_pkt_d   = '0;
    alu_out_d   = alu_out_q;
    rdata_out_d = rdata_out_q;
    if (state_q == IDLE && is_mem_op(in_ipacket.opcode)) begin
      state_d = ACC1;
      pkt_d   = in_ipacket;
      addr_d  = meat_addrgen_out;
      sr_d    = sr_store_in;
      alu_d   = meat_alu_out;
      hold_d  = hold;
    end else if (state_q == IDLE) begin
      out_pkt_d   = in_ipacket;
      alu_out_d   = meat_alu_out;
      rdata_out_d = '0;
    end
    if (ptr_rd && dmem_resp) begin
      state_d = PTR;
      addr_d  = dmem_rdata;
    end
    if (state_q == PTR) begin
      state_d = ACC2;
      hold_d  = 1'b0;
    end
    if (done) begin
      state_d     = IDLE;
      out_pkt_d   = pkt_q;
      alu_out_d   = alu_q;
      rdata_out_d = !ld ? '0 : (pkt_q.opcode == op_ldb) ? ldb_data : dmem_rdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      addr_q      <= '0;
      sr_q        <= '0;
      alu_q       <= '0;
      hold_q      <= 1'b0;
      out_pkt_q   <= '0;
      alu_out_q   <= '0;
      rdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      addr_q      <= addr_d;
      sr_q        <= sr_d;
      alu_q       <= alu_d;
      hold_q      <= hold_d;
      out_pkt_q   <= out_pkt_d;
      alu_out_q   <= alu_out_d;
      rdata_out_q <= rdata_out_d;
    end
  end
  assign dmem_addr     = {addr_q[15:1], 1'b0};
  assign dmem_read     = acc && (ptr_rd || ld);
  assign dmem_write    = acc && !ptr_rd && !ld;
  assign load_addr     = state_q == PTR;
  assign mem_stall     = state_q != IDLE;
  assign out_ipacket   = out_pkt_q;
  assign alu_pass_out  = alu_out_q;
  assign mem_rdata_out = rdata_out_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed scenario tests for mem_stage_ctrl with hand-computed expectations.
module tb_mem_stage_ctrl;
  import lc3b_types::*;
  logic        clk, rst_n, hold, dmem_resp;
  lc3b_ipacket in_ipacket;
  lc3b_word    meat_alu_out, meat_addrgen_out, sr_store_in, dmem_rdata;
  lc3b_word    dmem_addr, dmem_wdata, alu_pass_out, mem_rdata_out;
  logic        dmem_read, dmem_write, load_addr, mem_stall;
  logic [1:0]  dmem_wmask;
  lc3b_ipacket out_ipacket;
  lc3b_word    z_addr, z_wdata, z_alu, z_rdata;
  logic        z_read, z_write, z_load, z_stall;
  logic [1:0]  z_wmask;
  lc3b_ipacket z_pkt;
  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(.LDB_SEXT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_ipacket(in_ipacket), .meat_alu_out(meat_alu_out),
    .meat_addrgen_out(meat_addrgen_out), .sr_store_in(sr_store_in), .hold(hold),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_addr(dmem_addr),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .load_addr(load_addr), .mem_stall(mem_stall),
    .out_ipacket(out_ipacket), .alu_pass_out(alu_pass_out), .mem_rdata_out(mem_rdata_out)
  );
  mem_stage_ctrl #(.LDB_SEXT(1'b0)) dut_zext (
    .clk(clk), .rst_n(rst_n), .in_ipacket(in_ipacket), .meat_alu_out(meat_alu_out),
    .meat_addrgen_out(meat_addrgen_out), .sr_store_in(sr_store_in), .hold(hold),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_addr(z_addr),
    .dmem_read(z_read), .dmem_write(z_write), .dmem_wmask(z_wmask),
    .dmem_wdata(z_wdata), .load_addr(z_load), .mem_stall(z_stall),
    .out_ipacket(z_pkt), .alu_pass_out(z_alu), .mem_rdata_out(z_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic lc3b_ipacket mk(lc3b_opcode op, logic [2:0] dr, lc3b_word pc);
    lc3b_ipacket p;
    p.opcode = op;
    p.dr     = dr;
    p.pc     = pc;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(lc3b_ipacket p, lc3b_word alu, lc3b_word addr, lc3b_word sr, logic h);
    in_ipacket = p; meat_alu_out = alu; meat_addrgen_out = addr; sr_store_in = sr; hold = h;
    step();
    in_ipacket = '0; meat_alu_out = '0; meat_addrgen_out = '0; sr_store_in = '0; hold = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_ipacket = '0; meat_alu_out = '0; meat_addrgen_out = '0;
    sr_store_in = '0; hold = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0;
    #12;
    checks++;
    if ({dmem_read, dmem_write, load_addr, mem_stall} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {dmem_read, dmem_write, load_addr, mem_stall});
    end
    checks++;
    if (out_ipacket !== '0 || alu_pass_out !== 16'h0 || mem_rdata_out !== 16'h0) begin
      errors++; $display("FAIL reset_outs got pkt=%h alu=%h rd=%h want 0", out_ipacket, alu_pass_out, mem_rdata_out);
    end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    lc3b_ipacket p = mk(op_add, 3'd2, 16'h3000);
    present(p, 16'h1234, 16'h0, 16'h0, 1'b0);
    checks++;
    if (out_ipacket !== p || alu_pass_out !== 16'h1234) begin
      errors++; $display("FAIL add_pass got pkt=%h alu=%h want pkt=%h alu=1234", out_ipacket, alu_pass_out, p);
    end
    checks++;
    if (mem_stall !== 1'b0 || dmem_read !== 1'b0) begin
      errors++; $display("FAIL add_nostall got stall=%b read=%b want 0 0", mem_stall, dmem_read);
    end
    step();
    checks++;
    if (out_ipacket !== '0) begin
      errors++; $display("FAIL add_bubble_after got %h want 0", out_ipacket);
    end
  endtask

  task automatic test_ldr();
    lc3b_ipacket p = mk(op_ldr, 3'd3, 16'h3002);
    present(p, 16'h0041, 16'h0041, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || mem_stall !== 1'b1 || dmem_addr !== 16'h0040 || out_ipacket !== '0) begin
        errors++; $display("FAIL ldr_hold%0d got rd=%b wr=%b stall=%b addr=%h pkt=%h want 1 0 1 0040 0",
                           i, dmem_read, dmem_write, mem_stall, dmem_addr, out_ipacket);
      end
      if (i == 2) begin dmem_resp = 1'b1; dmem_rdata = 16'hBEEF; end
      step();
    end
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    checks++;
    if (out_ipacket !== p || mem_rdata_out !== 16'hBEEF || alu_pass_out !== 16'h0041 || mem_stall !== 1'b0 || dmem_read !== 1'b0) begin
      errors++; $display("FAIL ldr_done got pkt=%h rd=%h alu=%h stall=%b read=%b want %h BEEF 0041 0 0",
                         out_ipacket, mem_rdata_out, alu_pass_out, mem_stall, dmem_read, p);
    end
    step();
    checks++;
    if (out_ipacket !== '0) begin
      errors++; $display("FAIL ldr_one_cycle got %h want 0", out_ipacket);
    end
  endtask

  task automatic test_ldb();
    lc3b_ipacket p = mk(op_ldb, 3'd4, 16'h3004);
    present(p, 16'h0, 16'h0201, 16'h0, 1'b0);
    dmem_resp = 1'b1; dmem_rdata = 16'h8005;
    checks++;
    if (dmem_read !== 1'b1 || dmem_addr !== 16'h0200 || mem_stall !== 1'b1) begin
      errors++; $display("FAIL ldb_req got rd=%b addr=%h stall=%b want 1 0200 1", dmem_read, dmem_addr, mem_stall);
    end
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    checks++;
    if (out_ipacket !== p || mem_rdata_out !== 16'hFF80) begin
      errors++; $display("FAIL ldb_sext got pkt=%h rd=%h want %h FF80", out_ipacket, mem_rdata_out, p);
    end
    checks++;
    if (z_pkt !== p || z_rdata !== 16'h0080) begin
      errors++; $display("FAIL ldb_zext got pkt=%h rd=%h want %h 0080", z_pkt, z_rdata, p);
    end
    step();
  endtask

  task automatic test_stb();
    lc3b_ipacket p = mk(op_stb, 3'd1, 16'h3006);
    present(p, 16'h0, 16'h0300, 16'h12AB, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_wdata !== 16'hABAB || dmem_wmask !== 2'b01 || dmem_addr !== 16'h0300) begin
        errors++; $display("FAIL stb_req%0d got wr=%b rd=%b wdata=%h wmask=%b addr=%h want 1 0 ABAB 01 0300",
                           i, dmem_write, dmem_read, dmem_wdata, dmem_wmask, dmem_addr);
      end
      if (i == 1) dmem_resp = 1'b1;
      step();
    end
    dmem_resp = 1'b0;
    checks++;
    if (out_ipacket !== p || mem_rdata_out !== 16'h0 || dmem_write !== 1'b0) begin
      errors++; $display("FAIL stb_done got pkt=%h rd=%h wr=%b want %h 0000 0", out_ipacket, mem_rdata_out, dmem_write, p);
    end
    step();
  endtask

  task automatic test_ldi();
    lc3b_ipacket p = mk(op_ldi, 3'd5, 16'h3008);
    present(p, 16'h0, 16'h0100, 16'h0, 1'b1);
    checks++;
    if (dmem_read !== 1'b1 || dmem_addr !== 16'h0100 || load_addr !== 1'b0 || mem_stall !== 1'b1) begin
      errors++; $display("FAIL ldi_ptr_rd got rd=%b addr=%h la=%b stall=%b want 1 0100 0 1", dmem_read, dmem_addr, load_addr, mem_stall);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'h0400;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    checks++;
    if (load_addr !== 1'b1 || dmem_read !== 1'b0 || dmem_write !== 1'b0 || mem_stall !== 1'b1 || out_ipacket !== '0) begin
      errors++; $display("FAIL ldi_ptr got la=%b rd=%b wr=%b stall=%b pkt=%h want 1 0 0 1 0", load_addr, dmem_read, dmem_write, mem_stall, out_ipacket);
    end
    step();
    checks++;
    if (load_addr !== 1'b0 || dmem_read !== 1'b1 || dmem_addr !== 16'h0400 || mem_stall !== 1'b1) begin
      errors++; $display("FAIL ldi_acc2 got la=%b rd=%b addr=%h stall=%b want 0 1 0400 1", load_addr, dmem_read, dmem_addr, mem_stall);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'h5A5A;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    checks++;
    if (out_ipacket !== p || mem_rdata_out !== 16'h5A5A || mem_stall !== 1'b0) begin
      errors++; $display("FAIL ldi_done got pkt=%h rd=%h stall=%b want %h 5A5A 0", out_ipacket, mem_rdata_out, mem_stall, p);
    end
    step();
  endtask

  task automatic test_sti_reset();
    lc3b_ipacket p = mk(op_sti, 3'd6, 16'h300A);
    present(p, 16'h0, 16'h0111, 16'h7777, 1'b1);
    checks++;
    if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_addr !== 16'h0110 || dmem_wmask !== 2'b11) begin
      errors++; $display("FAIL sti_ptr_rd got rd=%b wr=%b addr=%h wmask=%b want 1 0 0110 11", dmem_read, dmem_write, dmem_addr, dmem_wmask);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'h0501;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    step();
    checks++;
    if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_addr !== 16'h0500 || dmem_wdata !== 16'h7777 || dmem_wmask !== 2'b11) begin
      errors++; $display("FAIL sti_acc2 got wr=%b rd=%b addr=%h wdata=%h wmask=%b want 1 0 0500 7777 11",
                         dmem_write, dmem_read, dmem_addr, dmem_wdata, dmem_wmask);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_write !== 1'b0 || mem_stall !== 1'b0 || out_ipacket !== '0 || load_addr !== 1'b0) begin
      errors++; $display("FAIL sti_async_rst got wr=%b stall=%b pkt=%h la=%b want 0 0 0 0", dmem_write, mem_stall, out_ipacket, load_addr);
    end
    step();
    #2 rst_n = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 16'h1111;
    step();
    dmem_resp = 1'b0; dmem_rdata = 16'h0;
    checks++;
    if (out_ipacket !== '0 || mem_stall !== 1'b0 || dmem_write !== 1'b0 || dmem_read !== 1'b0 || mem_rdata_out !== 16'h0) begin
      errors++; $display("FAIL sti_late_resp got pkt=%h stall=%b wr=%b rd=%b rdata=%h want 0",
                         out_ipacket, mem_stall, dmem_write, dmem_read, mem_rdata_out);
    end
  endtask

  task automatic test_back_to_back();
    lc3b_ipacket a = mk(op_and, 3'd7, 16'h3010);
    lc3b_ipacket s = mk(op_str, 3'd2, 16'h3012);
    present(a, 16'h00F0, 16'h0, 16'h0, 1'b0);
    checks++;
    if (out_ipacket !== a || alu_pass_out !== 16'h00F0) begin
      errors++; $display("FAIL b2b_and got pkt=%h alu=%h want %h 00F0", out_ipacket, alu_pass_out, a);
    end
    in_ipacket = s; meat_alu_out = 16'h0A0A; meat_addrgen_out = 16'h0203; sr_store_in = 16'hC0DE;
    step();
    in_ipacket = '0; meat_alu_out = '0; meat_addrgen_out = '0; sr_store_in = '0;
    dmem_resp = 1'b1;
    checks++;
    if (dmem_write !== 1'b1 || dmem_addr !== 16'h0202 || dmem_wdata !== 16'hC0DE || dmem_wmask !== 2'b11 || out_ipacket !== '0) begin
      errors++; $display("FAIL b2b_str_req got wr=%b addr=%h wdata=%h wmask=%b pkt=%h want 1 0202 C0DE 11 0",
                         dmem_write, dmem_addr, dmem_wdata, dmem_wmask, out_ipacket);
    end
    step();
    dmem_resp = 1'b0;
    checks++;
    if (out_ipacket !== s || alu_pass_out !== 16'h0A0A || mem_rdata_out !== 16'h0) begin
      errors++; $display("FAIL b2b_str_done got pkt=%h alu=%h rd=%h want %h 0A0A 0000", out_ipacket, alu_pass_out, mem_rdata_out, s);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_ldb();
    test_stb();
    test_ldi();
    test_sti_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
